// File: rtl/pixel_out_stage.sv
`default_nettype none
// ============================================================================
// pixel_out_stage : aligns raster with a fixed-latency colour source, expands RGB
//                   to 8 bpc, blanks outside DE, counts frames.
// Optional feature: PIXEL_OUT_TESTPAT_EN (8 vertical colour bars) | Rev 1.0
// ============================================================================
module pixel_out_stage #(
  parameter int CORDW      = 10,
  parameter int R_BITS     = 3,
  parameter int G_BITS     = 3,
  parameter int B_BITS     = 2,
  parameter int READ_LAT   = 1,
  parameter int EXPAND_REP = 1,
  parameter int FRAME_W    = 16
) (
  input  logic                            clk_pix,
  input  logic                            rst_pix,
  input  logic [CORDW-1:0]                sx,
  input  logic [CORDW-1:0]                sy,
  input  logic                            de,
  input  logic                            test_pat,
  output logic [CORDW-1:0]                rd_x,
  output logic [CORDW-1:0]                rd_y,
  input  logic [R_BITS+G_BITS+B_BITS-1:0] color_in,
  output logic [CORDW-1:0]                out_sx,
  output logic [CORDW-1:0]                out_sy,
  output logic                            out_de,
  output logic [7:0]                      out_r,
  output logic [7:0]                      out_g,
  output logic [7:0]                      out_b,
  output logic                            frame_start,
  output logic [FRAME_W-1:0]              frame_cnt
);
  localparam int CW = R_BITS + G_BITS + B_BITS;
  localparam int XW = READ_LAT * CORDW;

  // Channel value c occupies the low n bits; result is n->8 bit expansion.
  function automatic logic [7:0] expand8(input logic [7:0] c, input int n);
    logic [7:0] o;
    o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (EXPAND_REP != 0) o[3'(7 - i)] = c[3'(n - 1 - (i % n))];
      else if (i < n)      o[3'(7 - i)] = c[3'(n - 1 - i)];
    end
    return o;
  endfunction

  logic [XW-1:0]       sx_pipe_q, sx_pipe_d, sy_pipe_q, sy_pipe_d;
  logic [READ_LAT-1:0] de_pipe_q, de_pipe_d, vld_pipe_q, vld_pipe_d;
  logic [CORDW-1:0]    dly_sx, dly_sy;
  logic                dly_de, dly_vld;

  logic [CORDW-1:0]    out_sx_q, out_sx_d, out_sy_q, out_sy_d;
  logic                out_de_q, out_de_d, frame_start_q, frame_start_d;
  logic [7:0]          out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic [7:0]          exp_r, exp_g, exp_b;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;

  assign rd_x = sx;
  assign rd_y = sy;

  // vld marks stages loaded since reset, so flushed (0,0) never strobes.
  always_comb begin
    sx_pipe_d  = (sx_pipe_q << CORDW) | XW'(sx);
    sy_pipe_d  = (sy_pipe_q << CORDW) | XW'(sy);
    de_pipe_d  = (de_pipe_q << 1) | READ_LAT'(de);
    vld_pipe_d = (vld_pipe_q << 1) | READ_LAT'(1'b1);
  end

  assign dly_sx  = sx_pipe_q[XW-1 -: CORDW];
  assign dly_sy  = sy_pipe_q[XW-1 -: CORDW];
  assign dly_de  = de_pipe_q[READ_LAT-1];
  assign dly_vld = vld_pipe_q[READ_LAT-1];

`ifdef PIXEL_OUT_TESTPAT_EN
  logic [READ_LAT-1:0] tp_pipe_q, tp_pipe_d;
  logic                dly_tp;

  always_comb begin
    tp_pipe_d = (tp_pipe_q << 1) | READ_LAT'(test_pat);
  end

  assign dly_tp = tp_pipe_q[READ_LAT-1];

  always_ff @(posedge clk_pix) begin
    if (rst_pix) tp_pipe_q <= '0;
    else         tp_pipe_q <= tp_pipe_d;
  end
`else
  logic unused_test_pat;
  assign unused_test_pat = test_pat;
`endif

  always_comb begin
    exp_r = expand8(8'(color_in[CW-1 -: R_BITS]), R_BITS);
    exp_g = expand8(8'(color_in[B_BITS +: G_BITS]), G_BITS);
    exp_b = expand8(8'(color_in[0 +: B_BITS]), B_BITS);
  end

  always_comb begin
    out_sx_d = dly_sx;
    out_sy_d = dly_sy;
    out_de_d = dly_de;
    out_r_d  = 8'h00;
    out_g_d  = 8'h00;
    out_b_d  = 8'h00;
    if (dly_de) begin
      out_r_d = exp_r;
      out_g_d = exp_g;
      out_b_d = exp_b;
`ifdef PIXEL_OUT_TESTPAT_EN
      if (dly_tp) begin
        out_r_d = {8{dly_sx[CORDW-1]}};
        out_g_d = {8{dly_sx[CORDW-2]}};
        out_b_d = {8{dly_sx[CORDW-3]}};
      end
`endif
    end
    frame_start_d = dly_vld && (dly_sx == '0) && (dly_sy == '0);
    frame_cnt_d   = frame_cnt_q + FRAME_W'(frame_start_d);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      sx_pipe_q     <= '0;
      sy_pipe_q     <= '0;
      de_pipe_q     <= '0;
      vld_pipe_q    <= '0;
      out_sx_q      <= '0;
      out_sy_q      <= '0;
      out_de_q      <= 1'b0;
      out_r_q       <= 8'h00;
      out_g_q       <= 8'h00;
      out_b_q       <= 8'h00;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      sx_pipe_q     <= sx_pipe_d;
      sy_pipe_q     <= sy_pipe_d;
      de_pipe_q     <= de_pipe_d;
      vld_pipe_q    <= vld_pipe_d;
      out_sx_q      <= out_sx_d;
      out_sy_q      <= out_sy_d;
      out_de_q      <= out_de_d;
      out_r_q       <= out_r_d;
      out_g_q       <= out_g_d;
      out_b_q       <= out_b_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign out_sx      = out_sx_q;
  assign out_sy      = out_sy_q;
  assign out_de      = out_de_q;
  assign out_r       = out_r_q;
  assign out_g       = out_g_q;
  assign out_b       = out_b_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
